// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into a 32-bit word, checks the
// immediate for range/alignment, and streams legal words to consecutive
// instruction-memory word addresses. Erroneous field sets are consumed but
// never written; the first error code is kept until reset/clear.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous clear of pointer, count, error, pending write
//   in_valid/ready  field-set handshake
//   in_fmt..in_imm  instruction fields (fmt 0=R 1=I 2=S 3=B 4=U 5=J)
//   mem_we/ready    write request / memory accept
//   mem_addr/wdata  write address / encoded instruction
//   count, full     words accepted for writing, count == DEPTH
//   err, err_code   sticky error, first error (1 fmt, 2 range, 3 misaligned)
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] L_BASE  = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic        w_full;
  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_word;
  logic [1:0]  w_code;
  logic        w_sx11;   // imm[31:11] is a pure sign extension
  logic        w_sx12;
  logic        w_sx20;

  assign w_full   = (r_count == L_DEPTH);
  // A new word may be accepted in the same cycle the pending one completes.
  assign w_ready  = !w_full && (!r_we || mem_ready) && !clear;
  assign w_accept = in_valid && w_ready;

  assign w_sx11 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign w_sx12 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign w_sx20 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    w_word = '0;
    case (in_fmt)
      F_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      F_I: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      F_S: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      F_B: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      F_U: w_word = {in_imm[31:12], in_rd, in_opcode};
      F_J: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, in_opcode};
      default: w_word = '0;
    endcase
  end

  // Priority: illegal format, then misalignment, then range.
  always_comb begin
    w_code = 2'd0;
    if (in_fmt > F_J)
      w_code = 2'd1;
    else if ((in_fmt == F_B || in_fmt == F_J) && in_imm[0])
      w_code = 2'd3;
    else begin
      case (in_fmt)
        F_I, F_S: if (!w_sx11)        w_code = 2'd2;
        F_B:      if (!w_sx12)        w_code = 2'd2;
        F_J:      if (!w_sx20)        w_code = 2'd2;
        F_U:      if (|in_imm[11:0])  w_code = 2'd2;
        default:  w_code = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // A pending write is dropped here, not completed.
      r_we       <= 1'b0;
      r_addr     <= L_BASE;
      r_wdata    <= '0;
      r_ptr      <= L_BASE;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      if (r_we && mem_ready)
        r_we <= 1'b0;
      if (w_accept) begin
        if (w_code != 2'd0) begin
          r_err <= 1'b1;
          if (!r_err)
            r_err_code <= w_code;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= w_word;
          r_ptr   <= r_ptr + 1'b1;   // wraps modulo DEPTH
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign full      = w_full;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW = 2;
  localparam logic [AW-1:0] BASE = 2'd1;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready;
  logic [2:0]    in_fmt, in_funct3;
  logic [6:0]    in_opcode, in_funct7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full, err;
  logic [1:0]    err_code;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(1)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .full(full),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard entry: {addr, wdata}
  logic [AW+31:0] sb_q[$];

  logic [AW-1:0] m_ptr;
  logic [AW:0]   m_cnt;
  logic          m_err;
  logic [1:0]    m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from shifts/masks of the field values.
  function automatic logic [31:0] enc(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    case (fmt)
      3'd0: return (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
      3'd1: return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                   | (32'(rd) << 7) | 32'(op);
      3'd2: return (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(op);
      3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      3'd4: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (32'(rd) << 7) | 32'(op);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_code(input logic [2:0] fmt, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    if (fmt > 3'd5) return 2'd1;
    if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) return 2'd3;
    case (fmt)
      3'd1, 3'd2: if (s < -2048 || s > 2047) return 2'd2;
      3'd3:       if (s < -4096 || s > 4095) return 2'd2;
      3'd5:       if (s < -(1 << 20) || s > (1 << 20) - 1) return 2'd2;
      3'd4:       if ((imm % 32'd4096) != 0) return 2'd2;
      default: ;
    endcase
    return 2'd0;
  endfunction

  // Monitor: every completed write must match the oldest expected entry.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {30'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+31:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[AW+31:32]));
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic model_reset();
    sb_q.delete();
    m_ptr = BASE; m_cnt = '0; m_err = 1'b0; m_code = 2'd0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] want,
      output logic rdy0, output logic we0);
    int w;
    logic [1:0] c;
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    rdy0 = in_ready;
    we0  = mem_we;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      return;
    end
    c = model_code(fmt, imm);
    if (c == 2'd0) begin
      sb_q.push_back({m_ptr, want}); m_ptr++; m_cnt++;
    end else begin
      if (!m_err) m_code = c;
      m_err = 1'b1;
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    model_reset();
    #1 clear = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    @(negedge clk);
    chk({tag, "_count"}, 32'(count), 32'(m_cnt));
    chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, "_code"}, 32'(err_code), 32'(m_code));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r0, w0;
    logic [31:0] imm;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {30'd0, err, err_code[0]}, 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // addi x1,x0,5
    @(posedge clk); #1 mem_ready = 1'b1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, r0, w0);
    @(negedge clk);
    chk("addi_we", {31'd0, mem_we}, 32'd1);
    chk("addi_count", 32'(count), 32'd1);
    @(posedge clk); #1;
    do_clear();

    // stream without bubbles, pointer wraps, ends full
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, r0, w0);
    chk("s0_ready", {31'd0, r0}, 32'd1);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, r0, w0);
    chk("s1_ready", {31'd0, r0}, 32'd1); chk("s1_we", {31'd0, w0}, 32'd1);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, r0, w0);
    chk("s2_ready", {31'd0, r0}, 32'd1); chk("s2_we", {31'd0, w0}, 32'd1);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, r0, w0);
    chk("s3_ready", {31'd0, r0}, 32'd1); chk("s3_we", {31'd0, w0}, 32'd1);
    @(negedge clk);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("full_we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    do_clear();
    @(negedge clk);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_addr", 32'(mem_addr), 32'(BASE));
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_ready", {31'd0, in_ready}, 32'd1);
    chk("sb_drain_stream", sb_q.size(), 32'd0);
    @(posedge clk); #1;

    // errors
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'd0, r0, w0);
    chk_state("b_misal");
    @(posedge clk); #1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 32'd0, r0, w0);
    chk_state("i_range");
    @(posedge clk); #1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, r0, w0);
    chk_state("after_err");
    @(posedge clk); #1;
    do_clear();
    send(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, r0, w0);
    chk_state("fmt6");
    @(posedge clk); #1;
    do_clear();
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'd0, r0, w0);
    chk_state("u_low");
    @(posedge clk); #1;
    do_clear();
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100001, 32'd0, r0, w0);
    chk_state("j_prio");
    @(posedge clk); #1;
    do_clear();

    // immediate boundaries, all legal
    imm = 32'hFFF00000;
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, imm,
         enc(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, imm), r0, w0);
    imm = 32'hFFFFF800;
    send(3'd1, 7'h13, 3'd7, 7'd0, 5'd9, 5'd4, 5'd0, imm,
         enc(3'd1, 7'h13, 3'd7, 7'd0, 5'd9, 5'd4, 5'd0, imm), r0, w0);
    imm = 32'h000FFFFE;
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd31, 5'd0, 5'd0, imm,
         enc(3'd5, 7'h6F, 3'd0, 7'd0, 5'd31, 5'd0, 5'd0, imm), r0, w0);
    chk_state("bounds");
    @(posedge clk); #1;
    do_clear();

    // backpressure
    mem_ready = 1'b0;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, r0, w0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_we", {31'd0, mem_we}, 32'd1);
      chk("bp_addr", 32'(mem_addr), 32'(BASE));
      chk("bp_wdata", mem_wdata, 32'h00500093);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_hi", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_we_drop", {31'd0, mem_we}, 32'd0);
    chk("bp_sb", sb_q.size(), 32'd0);

    // clear with a pending write and in_valid
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      do_clear();
      mem_ready = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, r0, w0);
      if (k == 0) clear = 1'b1; else rst = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      if (k == 0) chk("drop_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      model_reset();
      #1 clear = 1'b0; rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk(k == 0 ? "drop_we_clr" : "drop_we_rst", {31'd0, mem_we}, 32'd0);
      chk(k == 0 ? "drop_cnt_clr" : "drop_cnt_rst", 32'(count), 32'd0);
      chk(k == 0 ? "drop_addr_clr" : "drop_addr_rst", 32'(mem_addr), 32'(BASE));
      mem_ready = 1'b1;
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
